// File: rtl/sel_scan_seq.sv
// Channel-select sequencer: walks a 3-bit index {a,b,c} through the set bits of a
// latched 8-bit mask, holding each index dwell+1 cycles, single sweep or continuous.
module sel_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         en_mask,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               sel_valid,
  output logic               busy,
  output logic               step,
  output logic               wrap,
  output logic               done
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_idx, w_idx_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell;
  logic [7:0]         r_mask;
  logic               r_mode;
  logic               r_sel_valid, w_sel_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_step, w_step_nxt;
  logic               r_wrap, w_wrap_nxt;
  logic               r_done, w_done_nxt;
  logic               w_load;
  logic [7:0]         w_above;

  function automatic logic [2:0] f_lowest(input logic [7:0] m);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) res = 3'(i);
    end
    return res;
  endfunction

  // Enabled channels strictly above the current index.
  assign w_above = r_mask & (8'hFE << r_idx);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_cnt_nxt       = r_cnt;
    w_sel_valid_nxt = r_sel_valid;
    w_busy_nxt      = r_busy;
    w_step_nxt      = 1'b0;
    w_wrap_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_load          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (en_mask != 8'd0)) begin
          w_state_nxt     = S_RUN;
          w_load          = 1'b1;
          w_idx_nxt       = f_lowest(en_mask);
          w_cnt_nxt       = '0;
          w_sel_valid_nxt = 1'b1;
          w_busy_nxt      = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt     = S_IDLE;
          w_idx_nxt       = 3'd0;
          w_cnt_nxt       = '0;
          w_sel_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
        end else if (r_cnt == r_dwell) begin
          w_cnt_nxt = '0;
          if (w_above != 8'd0) begin
            w_idx_nxt  = f_lowest(w_above);
            w_step_nxt = 1'b1;
          end else if (r_mode) begin
            w_idx_nxt  = f_lowest(r_mask);
            w_step_nxt = 1'b1;
            w_wrap_nxt = 1'b1;
          end else begin
            w_state_nxt     = S_IDLE;
            w_idx_nxt       = 3'd0;
            w_sel_valid_nxt = 1'b0;
            w_busy_nxt      = 1'b0;
            w_done_nxt      = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= '0;
      r_dwell     <= '0;
      r_mask      <= 8'd0;
      r_mode      <= 1'b0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_step      <= 1'b0;
      r_wrap      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sel_valid <= w_sel_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_step      <= w_step_nxt;
      r_wrap      <= w_wrap_nxt;
      r_done      <= w_done_nxt;
      if (w_load) begin
        r_mode  <= mode;
        r_dwell <= dwell;
        r_mask  <= en_mask;
      end
    end
  end

  assign {a, b, c}  = r_idx;
  assign sel_valid  = r_sel_valid;
  assign busy       = r_busy;
  assign step       = r_step;
  assign wrap       = r_wrap;
  assign done       = r_done;

endmodule

// File: tb/tb_sel_scan_seq.sv
// Self-checking bench for sel_scan_seq: a list/countdown reference model tracks the
// expected outputs every cycle, plus directed checks of the documented scenarios.
module tb_sel_scan_seq;

  localparam int DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               mode = 1'b0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [7:0]         en_mask = 8'd0;
  logic               a, b, c, sel_valid, busy, step, wrap, done;
  logic [7:0]         obs;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  // Reference model: list of enabled channels, position in it, cycles left on this one.
  int   m_list[$];
  int   m_pos;
  int   m_remain;
  int   m_dwell;
  bit   m_mode;
  bit   m_active;
  logic m_step, m_wrap, m_done;
  logic [7:0] m_exp;
  int   m_idx;

  sel_scan_seq #(.DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .dwell(dwell), .en_mask(en_mask),
    .a(a), .b(b), .c(c), .sel_valid(sel_valid), .busy(busy),
    .step(step), .wrap(wrap), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {a, b, c, sel_valid, busy, step, wrap, done};

  task automatic model_step();
    m_step = 1'b0; m_wrap = 1'b0; m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (start && en_mask != 8'd0) begin
        m_list.delete();
        for (int i = 0; i < 8; i++) if (en_mask[i]) m_list.push_back(i);
        m_pos = 0; m_dwell = int'(dwell); m_mode = mode;
        m_remain = m_dwell + 1; m_active = 1'b1;
      end
    end else if (stop) begin
      m_active = 1'b0;
    end else begin
      m_remain--;
      if (m_remain == 0) begin
        m_remain = m_dwell + 1;
        if (m_pos + 1 < m_list.size()) begin
          m_pos++; m_step = 1'b1;
        end else if (m_mode) begin
          m_pos = 0; m_step = 1'b1; m_wrap = 1'b1;
        end else begin
          m_active = 1'b0; m_done = 1'b1;
        end
      end
    end
    m_idx = m_active ? m_list[m_pos] : 0;
    m_exp = {3'(m_idx), m_active, m_active, m_step, m_wrap, m_done};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; en_mask = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (obs !== 8'd0) begin
        n_mis++; $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs, 8'd0);
      end
    end
    start = 1'b0; rst = 1'b0;
    tick();
    n_cmp++;
    if (obs !== m_exp) begin
      n_mis++; $display("FAIL reset_release cyc=%0d got=%b exp=%b", cyc, obs, m_exp);
    end
  endtask

  task automatic test_single_sweep();
    int steps = 0;
    int done_at = -1;
    en_mask = 8'hFF; dwell = 8'd2; mode = 1'b0; start = 1'b1;
    for (int t = 1; t <= 27; t++) begin
      tick();
      start = 1'b0;
      n_cmp++;
      if (obs !== m_exp) begin
        n_mis++; $display("FAIL sweep_trace cyc=%0d got=%b exp=%b", cyc, obs, m_exp);
      end
      if (step === 1'b1) steps++;
      if (done === 1'b1) done_at = t;
      if (t <= 24 && sel_valid !== 1'b1) begin
        n_mis++; $display("FAIL sweep_valid t=%0d got=%b exp=1", t, sel_valid);
      end
      if (t <= 24) n_cmp++;
    end
    n_cmp++;
    if (steps != 7) begin
      n_mis++; $display("FAIL sweep_steps got=%0d exp=7", steps);
    end
    n_cmp++;
    if (done_at != 25) begin
      n_mis++; $display("FAIL sweep_done_edge got=%0d exp=25", done_at);
    end
  endtask

  task automatic test_continuous();
    int seq[6] = '{2, 5, 7, 2, 5, 7};
    en_mask = 8'b1010_0100; dwell = 8'd0; mode = 1'b1; start = 1'b1;
    for (int t = 0; t < 9; t++) begin
      tick();
      start = 1'b0;
      n_cmp++;
      if (obs !== m_exp) begin
        n_mis++; $display("FAIL cont_trace cyc=%0d got=%b exp=%b", cyc, obs, m_exp);
      end
      if (t < 6) begin
        n_cmp++;
        if ({a, b, c} !== 3'(seq[t])) begin
          n_mis++; $display("FAIL cont_idx t=%0d got=%0d exp=%0d", t, {a, b, c}, seq[t]);
        end
      end
      n_cmp++;
      if (done !== 1'b0 || wrap !== (t > 0 && {a, b, c} == 3'd2)) begin
        n_mis++; $display("FAIL cont_wrap t=%0d got wrap=%b done=%b", t, wrap, done);
      end
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_edge_inputs();
    en_mask = 8'd0; start = 1'b1; mode = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
        n_mis++; $display("FAIL zero_mask_busy t=%0d got=%b exp=0", t, busy);
      end
    end
    en_mask = 8'b0000_1000; dwell = 8'd1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      n_cmp++;
      if (obs !== m_exp || {a, b, c} !== 3'd3 || step !== (t % 2 == 0) || wrap !== step) begin
        n_mis++; $display("FAIL single_bit t=%0d got=%b exp=%b", t, obs, m_exp);
      end
    end
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic test_stop();
    int guard = 0;
    en_mask = 8'hFF; dwell = 8'd3; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    while (!(m_active && m_idx == 4 && m_remain == 1) && guard < 100) begin
      tick(); guard++;
    end
    n_cmp++;
    if (guard >= 100) begin
      n_mis++; $display("FAIL stop_reach_idx4 got=timeout exp=idx4");
    end
    stop = 1'b1; start = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 8'd0 || obs !== m_exp) begin
      n_mis++; $display("FAIL stop_expiry got=%b exp=%b", obs, 8'd0);
    end
    stop = 1'b0; start = 1'b0;
    tick();
    n_cmp++;
    if (obs !== 8'd0) begin
      n_mis++; $display("FAIL stop_idle got=%b exp=%b", obs, 8'd0);
    end
  endtask

  task automatic test_latching();
    int hold = 0;
    int guard = 0;
    en_mask = 8'hFF; dwell = 8'd1; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; dwell = 8'd9; en_mask = 8'h01; mode = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (step !== 1'b1) hold++;
      n_cmp++;
      if (obs !== m_exp) begin
        n_mis++; $display("FAIL latch_trace cyc=%0d got=%b exp=%b", cyc, obs, m_exp);
      end
      n_cmp++;
      if (hold > 1) begin
        n_mis++; $display("FAIL latch_hold t=%0d got=%0d exp<=1", t, hold);
      end
      if (step === 1'b1) hold = 0;
    end
    while (!(m_active && m_idx == 5) && guard < 100) begin
      tick(); guard++;
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (obs !== 8'd0 || guard >= 100) begin
      n_mis++; $display("FAIL midrun_reset got=%b exp=%b guard=%0d", obs, 8'd0, guard);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 1500; t++) begin
      rst     = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 3) == 0);
      stop    = ($urandom_range(0, 24) == 0);
      mode    = 1'($urandom);
      dwell   = DWELL_W'($urandom_range(0, 3));
      en_mask = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      tick();
      n_cmp++;
      if (obs !== m_exp) begin
        n_mis++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, m_exp);
      end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    m_active = 1'b0; m_exp = 8'd0; m_idx = 0; m_pos = 0; m_remain = 0;
    @(negedge clk);
    test_reset();
    test_single_sweep();
    test_continuous();
    test_edge_inputs();
    test_stop();
    test_latching();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
